clk_sched_ctrl: RTL and testbench
=================================

Name: clk_sched_ctrl

Overview:
Control and configuration sequencer for the timing-wheel clock event scheduler. Holds the per-clock half-period table and clock enable mask, accepted through a valid/ready config port. Sequences the scheduler through freeze, wheel initialisation (clear all slots, seed slot 0) and run. Owns the scheduler's freeze input and its wheel slot write port.

Parameters:
CLOCK_NUMBER, 9, number of generated clocks
HP_WIDTH, 8, bits per half-period entry
MEM_SIZE, 32, timing-wheel slots; AW = $clog2(MEM_SIZE), IW = $clog2(CLOCK_NUMBER)

Ports:
clk_i  in  1  scheduler clock
rst_n_i  in  1  synchronous active-low reset
cfg_valid_i  in  1  config write request
cfg_ready_o  out  1  config write accepted when valid&ready
cfg_idx_i  in  IW  clock index to program
cfg_hp_i  in  HP_WIDTH  half-period in wheel slots
cfg_en_i  in  1  enable bit for that clock
start_i  in  1  single-cycle start request
stop_i  in  1  single-cycle stop request
freeze_o  out  1  scheduler freeze
wr_en_o  out  1  wheel slot write strobe
wr_addr_o  out  AW  wheel slot address
wr_data_o  out  CLOCK_NUMBER  wheel slot data
hp_o  out  CLOCK_NUMBER*HP_WIDTH  half-period table, entry i at [i*HP_WIDTH +: HP_WIDTH]
en_o  out  CLOCK_NUMBER  clock enable mask
state_o  out  2  00 IDLE, 01 INIT, 10 RUN
err_o  out  1  one-cycle error pulse
run_cnt_o  out  32  cycles spent in RUN since last start, saturating

Behaviour:
- Single clock domain; every action occurs at posedge clk_i. Reset is synchronous, active-low. All outputs are registered.
- Reset values: state IDLE, freeze_o=1, cfg_ready_o=1, wr_en_o=0, wr_addr_o=0, wr_data_o=0, hp entry i = i+3, en_o all ones, err_o=0, run_cnt_o=0.
- IDLE: freeze_o=1, cfg_ready_o=1.
  - Accepted cfg with cfg_idx_i>=CLOCK_NUMBER, cfg_hp_i==0 or cfg_hp_i>=MEM_SIZE: table unchanged, err_o pulses the next cycle.
  - Any other accepted cfg: hp[idx] and en[idx] are updated the next cycle.
  - start_i with stop_i low: if the effective en mask is zero, err_o pulses and the block stays IDLE. Otherwise go to INIT. The effective mask includes a same-cycle accepted cfg write, which is applied before INIT.
- INIT: freeze_o=1, cfg_ready_o=0, wr_en_o=1 for exactly MEM_SIZE consecutive cycles.
  - wr_addr_o runs 0..MEM_SIZE-1.
  - wr_data_o = en_o at addr 0, zero elsewhere.
  - After the last write, go to RUN.
  - Latency: start sampled at edge t gives the first write at t+1 and freeze_o=0 from t+MEM_SIZE+1.
- RUN: freeze_o=0, cfg_ready_o=0, wr_en_o=0. cfg_valid_i is held off by ready, not dropped. run_cnt_o clears on the INIT->RUN transition, then increments every RUN cycle and saturates at all ones.
- stop_i in INIT or RUN: return to IDLE next cycle, freeze_o=1, wr_en_o=0, cfg_ready_o=1. The wheel is left as-is. A later start always performs a full INIT.
- stop_i in IDLE: no effect.
- start_i and stop_i in the same cycle: stop wins. No err_o is raised.
- start_i in INIT or RUN: ignored.
- Reset asserted mid-INIT or mid-RUN: the next cycle shows reset values. Any partially written wheel is not repaired until the next start.
- err_o is a single-cycle pulse. When errors are back-to-back it is high on consecutive cycles.

Test Plan:
- Reset, then read the table -> hp_o entries 3..11, en_o=0x1FF, freeze_o=1, state_o=00, cfg_ready_o=1.
- Start from IDLE with defaults at cycle t -> wr_en_o high for cycles t+1..t+32, addr 0..31, data 0x1FF at addr 0 and 0 elsewhere. freeze_o=0 and state_o=10 from t+33. run_cnt_o=5 after 5 RUN cycles.
- Cfg writes idx=2 hp=0, idx=9 hp=4, idx=1 hp=32 -> err_o pulses each time and the table is unchanged. Then idx=1 hp=31 en=0 -> hp[1]=31 and en_o=0x1FD.
- Disable all clocks via 9 cfg writes with en=0, then start -> err_o pulse, state stays IDLE, wr_en_o never asserts.
- stop_i at the 10th INIT write -> next cycle IDLE, wr_en_o=0, freeze_o=1. A later start performs all 32 writes again.
- start_i and stop_i together in IDLE -> stays IDLE with no err_o. cfg_valid_i held during RUN -> cfg_ready_o=0 until stop, accepted the cycle after return to IDLE. rst_n_i low mid-RUN -> reset values next cycle.

Source files
------------

// File: rtl/clk_sched_ctrl.sv
// Control and configuration sequencer for the timing-wheel clock event scheduler.
// Holds the half-period/enable tables and sequences the scheduler through freeze, wheel init and run.
module clk_sched_ctrl #(
    parameter int CLOCK_NUMBER = 9,
    parameter int HP_WIDTH     = 8,
    parameter int MEM_SIZE     = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             cfg_valid_i,
    output logic                             cfg_ready_o,
    input  logic [$clog2(CLOCK_NUMBER)-1:0]  cfg_idx_i,
    input  logic [HP_WIDTH-1:0]              cfg_hp_i,
    input  logic                             cfg_en_i,
    input  logic                             start_i,
    input  logic                             stop_i,
    output logic                             freeze_o,
    output logic                             wr_en_o,
    output logic [$clog2(MEM_SIZE)-1:0]      wr_addr_o,
    output logic [CLOCK_NUMBER-1:0]          wr_data_o,
    output logic [CLOCK_NUMBER*HP_WIDTH-1:0] hp_o,
    output logic [CLOCK_NUMBER-1:0]          en_o,
    output logic [1:0]                       state_o,
    output logic                             err_o,
    output logic [31:0]                      run_cnt_o
);

    localparam int AW = $clog2(MEM_SIZE);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_INIT = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    logic                             cfg_fire;
    logic                             cfg_ok;
    logic [CLOCK_NUMBER-1:0]          en_next;
    logic [CLOCK_NUMBER*HP_WIDTH-1:0] hp_next;

    // Tables as they will look after this cycle's config write; start uses this mask.
    always_comb begin
        cfg_fire = cfg_valid_i && cfg_ready_o;
        cfg_ok   = (32'(cfg_idx_i) < CLOCK_NUMBER) && (cfg_hp_i != '0) &&
                   (32'(cfg_hp_i) < MEM_SIZE);
        en_next  = en_o;
        hp_next  = hp_o;
        if (cfg_fire && cfg_ok) begin
            for (int i = 0; i < CLOCK_NUMBER; i++) begin
                if (32'(cfg_idx_i) == i) begin
                    en_next[i]                    = cfg_en_i;
                    hp_next[i*HP_WIDTH +: HP_WIDTH] = cfg_hp_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_o     <= ST_IDLE;
            freeze_o    <= 1'b1;
            cfg_ready_o <= 1'b1;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            en_o        <= '1;
            err_o       <= 1'b0;
            run_cnt_o   <= '0;
            for (int i = 0; i < CLOCK_NUMBER; i++) begin
                hp_o[i*HP_WIDTH +: HP_WIDTH] <= HP_WIDTH'(i + 3);
            end
        end else begin
            err_o <= 1'b0;
            if (cfg_fire) begin
                if (cfg_ok) begin
                    en_o <= en_next;
                    hp_o <= hp_next;
                end else begin
                    err_o <= 1'b1;
                end
            end

            case (state_o)
                ST_IDLE: begin
                    if (start_i && !stop_i) begin
                        if (en_next == '0) begin
                            err_o <= 1'b1;
                        end else begin
                            state_o     <= ST_INIT;
                            cfg_ready_o <= 1'b0;
                            wr_en_o     <= 1'b1;
                            wr_addr_o   <= '0;
                            wr_data_o   <= en_next;
                        end
                    end
                end
                ST_INIT: begin
                    if (stop_i) begin
                        state_o     <= ST_IDLE;
                        freeze_o    <= 1'b1;
                        cfg_ready_o <= 1'b1;
                        wr_en_o     <= 1'b0;
                        wr_addr_o   <= '0;
                        wr_data_o   <= '0;
                    end else if (wr_addr_o == AW'(MEM_SIZE - 1)) begin
                        state_o   <= ST_RUN;
                        freeze_o  <= 1'b0;
                        wr_en_o   <= 1'b0;
                        wr_addr_o <= '0;
                        wr_data_o <= '0;
                        run_cnt_o <= '0;
                    end else begin
                        wr_addr_o <= wr_addr_o + 1'b1;
                        wr_data_o <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop_i) begin
                        state_o     <= ST_IDLE;
                        freeze_o    <= 1'b1;
                        cfg_ready_o <= 1'b1;
                    end else if (run_cnt_o != '1) begin
                        run_cnt_o <= run_cnt_o + 1'b1;
                    end
                end
                default: begin
                    state_o     <= ST_IDLE;
                    freeze_o    <= 1'b1;
                    cfg_ready_o <= 1'b1;
                    wr_en_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_sched_ctrl.sv
// Directed self-checking bench for clk_sched_ctrl: reset, init sweep, config errors,
// zero-mask start, stop mid-init, held config during run and reset mid-run.
module tb_clk_sched_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [3:0]  cfg_idx_i;
    logic [7:0]  cfg_hp_i;
    logic        cfg_en_i;
    logic        start_i;
    logic        stop_i;
    logic        freeze_o;
    logic        wr_en_o;
    logic [4:0]  wr_addr_o;
    logic [8:0]  wr_data_o;
    logic [71:0] hp_o;
    logic [8:0]  en_o;
    logic [1:0]  state_o;
    logic        err_o;
    logic [31:0] run_cnt_o;

    int checks_total  = 0;
    int checks_passed = 0;

    clk_sched_ctrl dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_hp_i    (cfg_hp_i),
        .cfg_en_i    (cfg_en_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .freeze_o    (freeze_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .hp_o        (hp_o),
        .en_o        (en_o),
        .state_o     (state_o),
        .err_o       (err_o),
        .run_cnt_o   (run_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hp_entry(input int i);
        return 32'(hp_o[i*8 +: 8]);
    endfunction

    task automatic apply_stimulus(input logic v, input logic [3:0] idx, input logic [7:0] hp,
                                  input logic en, input logic st, input logic sp);
        cfg_valid_i = v;
        cfg_idx_i   = idx;
        cfg_hp_i    = hp;
        cfg_en_i    = en;
        start_i     = st;
        stop_i      = sp;
    endtask

    // Walks the 32 init writes from the first one onward, then lands on the first RUN cycle.
    task automatic init_sweep(input logic [8:0] mask);
        logic [15:0] exp_word;
        for (int k = 0; k < 32; k++) begin
            exp_word = {1'b1, 1'b1, 5'(k), (k == 0) ? mask : 9'h000};
            check_output($sformatf("init_write_%0d", k),
                         32'({freeze_o, wr_en_o, wr_addr_o, wr_data_o}), 32'(exp_word));
            step();
        end
        check_output("run_state", 32'(state_o), 32'h2);
        check_output("run_freeze", 32'(freeze_o), 32'h0);
        check_output("run_wr_en", 32'(wr_en_o), 32'h0);
        check_output("run_ready", 32'(cfg_ready_o), 32'h0);
        check_output("run_cnt_start", run_cnt_o, 32'd0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        check_output("rst_state", 32'(state_o), 32'h0);
        check_output("rst_freeze", 32'(freeze_o), 32'h1);
        check_output("rst_ready", 32'(cfg_ready_o), 32'h1);
        check_output("rst_wr_en", 32'(wr_en_o), 32'h0);
        check_output("rst_en", 32'(en_o), 32'h1FF);
        check_output("rst_err", 32'(err_o), 32'h0);
        check_output("rst_run_cnt", run_cnt_o, 32'd0);
        for (int i = 0; i < 9; i++) begin
            check_output($sformatf("rst_hp_%0d", i), hp_entry(i), 32'(i + 3));
        end
        rst_n_i = 1'b1;
        step();

        $display("[TB] start with default table");
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_output("init_state", 32'(state_o), 32'h1);
        check_output("init_ready", 32'(cfg_ready_o), 32'h0);
        init_sweep(9'h1FF);
        for (int i = 0; i < 5; i++) step();
        check_output("run_cnt_5", run_cnt_o, 32'd5);
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_output("run_ignores_start", 32'(state_o), 32'h2);
        check_output("run_cnt_6", run_cnt_o, 32'd6);
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_output("stop_run_state", 32'(state_o), 32'h0);
        check_output("stop_run_freeze", 32'(freeze_o), 32'h1);
        check_output("stop_run_ready", 32'(cfg_ready_o), 32'h1);

        $display("[TB] rejected config writes back to back");
        apply_stimulus(1'b1, 4'd2, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_output("err_hp_zero", 32'(err_o), 32'h1);
        apply_stimulus(1'b1, 4'd9, 8'd4, 1'b1, 1'b0, 1'b0);
        step();
        check_output("err_idx_range", 32'(err_o), 32'h1);
        apply_stimulus(1'b1, 4'd1, 8'd32, 1'b1, 1'b0, 1'b0);
        step();
        check_output("err_hp_range", 32'(err_o), 32'h1);
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("err_drops", 32'(err_o), 32'h0);
        check_output("err_hp1_kept", hp_entry(1), 32'd4);
        check_output("err_hp2_kept", hp_entry(2), 32'd5);
        check_output("err_en_kept", 32'(en_o), 32'h1FF);

        apply_stimulus(1'b1, 4'd1, 8'd31, 1'b0, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_output("cfg_ok_err", 32'(err_o), 32'h0);
        check_output("cfg_hp1", hp_entry(1), 32'd31);
        check_output("cfg_en", 32'(en_o), 32'h1FD);

        $display("[TB] start with every clock disabled");
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, 4'(i), 8'd5, 1'b0, 1'b0, 1'b0);
            step();
        end
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_output("all_off_en", 32'(en_o), 32'h000);
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_output("zero_mask_err", 32'(err_o), 32'h1);
        check_output("zero_mask_state", 32'(state_o), 32'h0);
        check_output("zero_mask_wr_en", 32'(wr_en_o), 32'h0);
        step();
        check_output("zero_mask_err_drop", 32'(err_o), 32'h0);
        check_output("zero_mask_wr_en_later", 32'(wr_en_o), 32'h0);

        $display("[TB] start with same-cycle enable, stop at 10th write");
        apply_stimulus(1'b1, 4'd0, 8'd5, 1'b1, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_output("merge_state", 32'(state_o), 32'h1);
        check_output("merge_en", 32'(en_o), 32'h001);
        check_output("merge_data", 32'(wr_data_o), 32'h001);
        check_output("merge_err", 32'(err_o), 32'h0);
        for (int k = 1; k < 10; k++) step();
        check_output("tenth_addr", 32'(wr_addr_o), 32'd9);
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_output("stop_init_state", 32'(state_o), 32'h0);
        check_output("stop_init_wr_en", 32'(wr_en_o), 32'h0);
        check_output("stop_init_freeze", 32'(freeze_o), 32'h1);
        check_output("stop_init_ready", 32'(cfg_ready_o), 32'h1);
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        init_sweep(9'h001);

        $display("[TB] config held off during run");
        apply_stimulus(1'b1, 4'd3, 8'd7, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check_output("held_ready", 32'(cfg_ready_o), 32'h0);
        check_output("held_hp3", hp_entry(3), 32'd5);
        apply_stimulus(1'b1, 4'd3, 8'd7, 1'b1, 1'b0, 1'b1);
        step();
        apply_stimulus(1'b1, 4'd3, 8'd7, 1'b1, 1'b0, 1'b0);
        check_output("held_back_idle", 32'(state_o), 32'h0);
        check_output("held_not_yet", hp_entry(3), 32'd5);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_output("held_accepted_hp3", hp_entry(3), 32'd7);
        check_output("held_accepted_en", 32'(en_o), 32'h009);

        $display("[TB] start and stop together in idle");
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_output("both_state", 32'(state_o), 32'h0);
        check_output("both_err", 32'(err_o), 32'h0);
        check_output("both_wr_en", 32'(wr_en_o), 32'h0);

        $display("[TB] reset during run");
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        init_sweep(9'h009);
        step();
        step();
        check_output("pre_rst_cnt", run_cnt_o, 32'd2);
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        check_output("mid_rst_state", 32'(state_o), 32'h0);
        check_output("mid_rst_freeze", 32'(freeze_o), 32'h1);
        check_output("mid_rst_ready", 32'(cfg_ready_o), 32'h1);
        check_output("mid_rst_en", 32'(en_o), 32'h1FF);
        check_output("mid_rst_hp1", hp_entry(1), 32'd4);
        check_output("mid_rst_hp3", hp_entry(3), 32'd6);
        check_output("mid_rst_cnt", run_cnt_o, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
